// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: fetch/decode/execute/mem/write-back sequencing.
// Optional macro MULTICYCLE_ADDI_EN adds the ADDI_EX/ADDI_WB path for opcode 001000.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEM_ADDR = STATE_W'(2),
        MEM_RD   = STATE_W'(3),
        MEM_WB   = STATE_W'(4),
        MEM_WR   = STATE_W'(5),
        EXEC     = STATE_W'(6),
        R_WB     = STATE_W'(7),
        BRANCH   = STATE_W'(8),
`ifdef MULTICYCLE_ADDI_EN
        JUMP     = STATE_W'(9),
        ADDI_EX  = STATE_W'(10),
        ADDI_WB  = STATE_W'(11)
`else
        JUMP     = STATE_W'(9)
`endif
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    state_t cur, nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= FETCH;
        else        cur <= nxt;
    end

    assign state = cur;

    // Every output is forced low while reset is held, even though cur already reads FETCH.
    always_comb begin
        nxt         = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        if (rst_n) begin
            case (cur)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    nxt     = mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    case (opcode)
                        OP_R:          nxt = EXEC;
                        OP_LW, OP_SW:  nxt = MEM_ADDR;
                        OP_BEQ:        nxt = BRANCH;
                        OP_J:          nxt = JUMP;
`ifdef MULTICYCLE_ADDI_EN
                        OP_ADDI:       nxt = ADDI_EX;
`endif
                        default: begin
                            illegal_op = 1'b1;
                            nxt        = FETCH;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    nxt     = (opcode == OP_LW) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    nxt     = mem_ready ? MEM_WB : MEM_RD;
                end
                MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    nxt      = FETCH;
                end
                MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    nxt      = mem_ready ? FETCH : MEM_WR;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                    nxt     = R_WB;
                end
                R_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    nxt      = FETCH;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    nxt         = FETCH;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    nxt      = FETCH;
                end
`ifdef MULTICYCLE_ADDI_EN
                ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    nxt     = ADDI_WB;
                end
                ADDI_WB: begin
                    RegWrite = 1'b1;
                    nxt      = FETCH;
                end
`endif
                default: nxt = FETCH;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath; sits directly upstream of the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and write-back steps.
- Drives ALUOp[1:0] plus all datapath enables and mux selects.
- Stalls on instruction and data memory accesses through a ready handshake.

Parameters:
- STATE_W, 4, width of the state register and the debug state output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instr[31:26], read from the instruction register
- mem_ready  input  1  memory has completed the current read or write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU zero (branch)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  write-back data select: 1 = MDR
- RegDst  output  1  destination register select: 1 = rd, 0 = rt
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSource  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded
- state  output  STATE_W  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
- Unused state codes go to FETCH.
- Reset: rst_n low forces state=FETCH asynchronously. All outputs are 0 while rst_n is low.
- The first active cycle after reset release is FETCH.
- Outputs are Moore-decoded from state only, except the mem_ready-qualified enables listed below. Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by opcode: 000000→EXEC, 100011 or 101011→MEM_ADDR, 000100→BRANCH, 000010→JUMP, 001000→ADDI_EX.
  - Any other opcode: illegal_op=1 for this cycle, next state FETCH.
- MEM_ADDR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: MEM_RD if opcode=100011, else MEM_WR.
- MEM_RD:
  - Outputs: MemRead=1, IorD=1.
  - Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB:
  - Outputs: RegWrite=1, MemtoReg=1, RegDst=0.
  - Next state FETCH.
- MEM_WR:
  - Outputs: MemWrite=1, IorD=1.
  - Holds until mem_ready=1, then goes to FETCH.
  - MemWrite stays high for every stalled cycle.
- EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next state R_WB.
- R_WB:
  - Outputs: RegWrite=1, RegDst=1, MemtoReg=0.
  - Next state FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - Next state FETCH.
- JUMP:
  - Outputs: PCWrite=1, PCSource=10.
  - Next state FETCH.
- ADDI_EX:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state ADDI_WB.
- ADDI_WB:
  - Outputs: RegWrite=1, RegDst=0, MemtoReg=0.
  - Next state FETCH.
- CPI with mem_ready held at 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- opcode is sampled every cycle and must stay stable from DECODE until the instruction completes; the IR holds it.
- Reset asserted in any state, including during a memory stall, returns to FETCH immediately. No partial write-back occurs after reset is asserted.
- mem_ready is ignored in every state other than FETCH, MEM_RD and MEM_WR.

Optional Feature:
- Macro: MULTICYCLE_ADDI_EN.
- Defined: addi (001000) is decoded to ADDI_EX → ADDI_WB as described above.
- Undefined:
  - States ADDI_EX and ADDI_WB are not implemented.
  - Opcode 001000 is treated as illegal: illegal_op pulses in DECODE and the next state is FETCH.
  - State codes 10 and 11 are unreachable and map to FETCH.

Test Plan:
- Reset then R-type: opcode=000000, mem_ready=1 → state 0,1,6,7,0; ALUOp=10 in EXEC; RegWrite=1 and RegDst=1 in R_WB; illegal_op never set.
- lw with stall: opcode=100011, mem_ready=0 for 2 cycles in MEM_RD → state 0,1,2,3,3,3,4,0; IorD=1 and MemRead=1 throughout MEM_RD; MemtoReg=1 in MEM_WB.
- Fetch stall: mem_ready=0 for 3 cycles after reset → state stays 0; IRWrite=0 and PCWrite=0 until mem_ready=1, then both equal 1 for exactly that cycle.
- Branch and jump:
  - beq (000100) → BRANCH with ALUOp=01, PCWriteCond=1, PCSource=01.
  - j (000010) → JUMP with PCWrite=1, PCSource=10; each returns to FETCH the next cycle.
- Illegal and reset: opcode=111111 → illegal_op=1 for exactly one cycle in DECODE, next state 0. Separately, rst_n driven low during MEM_WR stall → state=0 and MemWrite=0 immediately, without waiting for a clock edge.
- Optional feature, opcode=001000:
  - With MULTICYCLE_ADDI_EN → state 0,1,10,11,0; ALUSrcB=10 in ADDI_EX; RegWrite=1 and RegDst=0 in ADDI_WB.
  - Without it → illegal_op pulse and state 0,1,0.
